puf_host_16: RTL and testbench
==============================

# puf_host_16

Host-side initiator for the 16-bit PUF UART link. It sweeps a range of 16-bit challenges and sends each one to the PUF device as two UART bytes. For each challenge it collects the device's two-byte response and presents the pair as a challenge-response record (CRP) on a ready/valid port. It sits in the tester FPGA, cabled to the PUF board's `rx`/`tx_out` pins, and feeds a CRP logger or checker downstream.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868 — clock cycles per UART bit (100 MHz / 115200 baud).
- `TIMEOUT_CYCLES`, 2_000_000 — response watchdog limit, in clk cycles; used only when the watchdog is compiled in.

Ports:
- `clk` in 1 — single system clock.
- `rst_n` in 1 — reset; one clock; reset is asynchronous and active-low.
- `start` in 1 — one-cycle pulse that launches a sweep; ignored while `busy`.
- `chal_first` in 16 — first challenge, in binary; sampled on `start`.
- `chal_count` in 16 — number of challenges in the sweep; sampled on `start`.
- `tx_out` out 1 — serial line to the device's `rx`; idles high.
- `rx_in` in 1 — serial line from the device's `tx_out`; asynchronous.
- `crp_valid` out 1 — a CRP record is available.
- `crp_ready` in 1 — downstream accepts the record.
- `crp_challenge` out 16 — challenge of the current record.
- `crp_response` out 16 — response of the current record.
- `busy` out 1 — a sweep is in progress.
- `done` out 1 — one-cycle pulse at the end of a sweep.
- `timeout_err` out 1 — sticky; cleared by the next accepted `start`.

## Operation
- Link framing, both directions:
  - 8N1, LSB-first bits.
  - Each 16-bit word is sent as two bytes, low byte first.
  - At least 1 idle bit-time between the two bytes.
- Challenges are sent as binary. The device applies its own Gray conversion.
- FSM states and transitions:
  - IDLE → SEND_LO on an accepted `start` with `chal_count` ≠ 0.
  - SEND_LO → SEND_HI.
  - SEND_HI → WAIT_LO, once the stop bit of the high byte is complete.
  - WAIT_LO → WAIT_HI, once the low response byte is received.
  - WAIT_HI → EMIT, once the high response byte is received.
  - EMIT → NEXT on `crp_valid` && `crp_ready`.
  - NEXT → SEND_LO if the remaining count is > 0, otherwise → IDLE with a `done` pulse.
- `start` with `chal_count` = 0: assert `done` on the next cycle, send no traffic, leave `busy` low.
- Challenge arithmetic:
  - Next challenge = current + 1, modulo 2^16. 16'hFFFF wraps to 16'h0000.
  - The remaining count is a 16-bit down-counter.
- Receiver framing errors:
  - A byte whose stop bit is sampled low is discarded.
  - The receiver stays in the same WAIT state.
- Bytes that arrive in IDLE, SEND_LO or SEND_HI are discarded.
- Back-pressure: EMIT holds `crp_valid` and the record stable until the handshake. No further challenge is sent while in EMIT.
- `start` while `busy` is ignored. Sweep parameters do not change mid-sweep.

## Timing
- Reset values:
  - `tx_out` = 1.
  - `crp_valid`, `busy`, `done`, `timeout_err` = 0.
  - `crp_challenge` and `crp_response` = 16'h0000.
  - FSM = IDLE.
- Reset asserted mid-frame: `tx_out` returns high asynchronously and the partial frame is abandoned.
- Start-bit timing:
  - `start` sampled at edge N → `busy` = 1 at N+1.
  - The start bit of the low byte drives `tx_out` low from N+1.
- Each byte is exactly 10·`CLKS_PER_BIT` cycles. The high byte begins 1 bit-time after the low byte's stop bit ends.
- `rx_in` path:
  - Passes through a 2-FF synchronizer.
  - A start bit is confirmed at half a bit-time.
  - Data bits are sampled mid-bit.
- `crp_valid` rises 1 cycle after the mid-stop-bit sample of the high response byte.
- `done` is asserted in the cycle `busy` falls.

## Configuration
- `PUF_HOST_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in WAIT_LO/WAIT_HI, reset on each state entry.
  - When it reaches `TIMEOUT_CYCLES`: abort the sweep, set `timeout_err`, pulse `done`, return to IDLE, emit no record.
- Not defined: no watchdog counter is built, the FSM waits indefinitely, and `timeout_err` is tied to 0.

## Structure
- Package `puf_host_pkg` holds:
  - The FSM state enum.
  - `UART_FRAME_BITS` = 10.
  - `PUF_CHECK_WORD` = 16'hABCD, for benches and downstream checkers.
- Sub-module `puf_host_uart_rx8` contains the synchronizer, the start-bit qualifier and the 8-bit deserializer. It outputs `byte_valid` for one cycle and `byte_data`.
- The transmit serializer stays inline in the top FSM.

## Test plan
- Reset with `rx_in` = 1 → `tx_out` = 1, all flags low. Assert reset mid-byte → `tx_out` high within the same cycle.
- Single exchange:
  - Stimulus: `chal_first` = 16'h1234, `chal_count` = 1; device model replies 16'hABCD.
  - Bytes on `tx_out`: 8'h34 then 8'h12.
  - Required record: `crp_challenge` = 16'h1234, `crp_response` = 16'hABCD; then `done` pulses once.
- Wrap-around: `chal_first` = 16'hFFFE, `chal_count` = 3 → records with challenges FFFE, FFFF, 0000 in order.
- Back-pressure: hold `crp_ready` = 0 for 5000 cycles → record stable, `tx_out` idle high, no second challenge sent.
- Framing error: a response byte with a low stop bit is discarded; the next valid 2 bytes (8'hEF, 8'hBE) → `crp_response` = 16'hBEEF.
- With `PUF_HOST_TIMEOUT_EN` defined and a silent device → after `TIMEOUT_CYCLES`: `timeout_err` = 1, `done` pulses, no `crp_valid`. A new `start` clears `timeout_err`.

Source files
------------

// File: rtl/puf_host_pkg.sv
// Shared types and constants for the 16-bit PUF UART host.
// Holds the host FSM state enum, UART frame geometry and the check word.
// Imported by puf_host_16 and puf_host_uart_rx8.
package puf_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_LO,
    SEND_HI,
    WAIT_LO,
    WAIT_HI,
    EMIT,
    NEXT
  } state_t;

  // start + 8 data + stop
  localparam int UART_FRAME_BITS = 10;

  // Known response word used by benches and downstream checkers.
  localparam logic [15:0] PUF_CHECK_WORD = 16'hABCD;

  // Transmit frame, LSB first: start(0), data[7:0], stop(1), then one
  // extra idle-high bit that provides the inter-byte gap.
  function automatic logic [UART_FRAME_BITS:0] uart_frame(input logic [7:0] data);
    return {2'b11, data, 1'b0};
  endfunction

endpackage

// File: rtl/puf_host_uart_rx8.sv
// UART 8N1 byte receiver: 2-FF synchronizer, start-bit qualifier, deserializer.
// Latency: byte_valid pulses one cycle after the mid-stop-bit sample.
// Backpressure: none; byte_valid is a one-cycle pulse, a frame with a low stop bit is dropped.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_in             asynchronous serial input, idles high
//   byte_valid        one-cycle strobe for a correctly framed byte
//   byte_data         received byte, held until the next valid byte
module puf_host_uart_rx8 #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] byte_data
);
  import puf_host_pkg::*;

  localparam int CW        = $clog2(CLKS_PER_BIT + 1);
  localparam int DATA_BITS = UART_FRAME_BITS - 2;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     rx_state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Synchronizer plus one history stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      byte_valid <= 1'b0;
      case (rx_state)
        // A falling edge (not just a low level) starts a frame, so a line
        // still low after a bad stop bit cannot retrigger a bogus byte.
        R_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) rx_state <= R_START;
        end
        R_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            rx_state <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'(DATA_BITS - 1)) rx_state <= R_STOP;
            else                              bit_idx  <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            rx_state <= R_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/puf_host_16.sv
// Host initiator for the 16-bit PUF UART link: sweeps challenges, returns CRP records.
// Latency: start bit of the first challenge one cycle after start; crp_valid one cycle after the high response byte.
// Backpressure: crp_valid/crp_ready; EMIT holds the record and sends no further challenge until accepted.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, chal_first,         sweep launch pulse and parameters (sampled on start, ignored while busy)
//   chal_count
//   tx_out / rx_in             serial lines to / from the PUF device (8N1, low byte first)
//   crp_valid, crp_ready,      challenge-response record handshake
//   crp_challenge, crp_response
//   busy, done, timeout_err    sweep status; timeout_err is sticky until the next accepted start
//
// Build option: define PUF_HOST_TIMEOUT_EN to build the response watchdog
// (TIMEOUT_CYCLES); without it the host waits indefinitely and timeout_err is 0.
module puf_host_16 #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] chal_first,
  input  logic [15:0] chal_count,
  output logic        tx_out,
  input  logic        rx_in,
  output logic        crp_valid,
  input  logic        crp_ready,
  output logic [15:0] crp_challenge,
  output logic [15:0] crp_response,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);
  import puf_host_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  // Low byte runs one extra bit-time (the idle gap) before the high byte.
  localparam logic [3:0] LO_LAST = 4'(UART_FRAME_BITS);
  localparam logic [3:0] HI_LAST = 4'(UART_FRAME_BITS - 1);

  state_t                   state;
  logic [15:0]              cur_chal;
  logic [15:0]              remaining;
  logic [7:0]               resp_lo;
  logic [UART_FRAME_BITS:0] tx_shift;
  logic [3:0]               tx_bit_idx;
  logic [CW-1:0]            tx_clk_cnt;
  logic                     tx_bit_end;
  logic                     byte_valid;
  logic [7:0]               byte_data;

  assign tx_bit_end = (tx_clk_cnt == BIT_LAST);

`ifdef PUF_HOST_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_expired;
  logic          timeout_q;
  assign wd_expired  = (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_err = 1'b0;
`endif

  puf_host_uart_rx8 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur_chal      <= '0;
      remaining     <= '0;
      resp_lo       <= '0;
      tx_shift      <= '1;
      tx_bit_idx    <= '0;
      tx_clk_cnt    <= '0;
      tx_out        <= 1'b1;
      crp_valid     <= 1'b0;
      crp_challenge <= '0;
      crp_response  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef PUF_HOST_TIMEOUT_EN
      wd_cnt        <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (start) begin
`ifdef PUF_HOST_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (chal_count != 16'h0000) begin
              cur_chal   <= chal_first;
              remaining  <= chal_count;
              busy       <= 1'b1;
              state      <= SEND_LO;
              tx_shift   <= uart_frame(chal_first[7:0]);
              tx_out     <= 1'b0;
              tx_bit_idx <= '0;
              tx_clk_cnt <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end

        // tx_out always mirrors tx_shift[0]; shifting in ones keeps the line
        // high once the frame is exhausted.
        SEND_LO: begin
          if (tx_bit_end) begin
            tx_clk_cnt <= '0;
            if (tx_bit_idx == LO_LAST) begin
              state      <= SEND_HI;
              tx_shift   <= uart_frame(cur_chal[15:8]);
              tx_out     <= 1'b0;
              tx_bit_idx <= '0;
            end else begin
              tx_shift   <= {1'b1, tx_shift[UART_FRAME_BITS:1]};
              tx_out     <= tx_shift[1];
              tx_bit_idx <= tx_bit_idx + 1'b1;
            end
          end else begin
            tx_clk_cnt <= tx_clk_cnt + 1'b1;
          end
        end

        SEND_HI: begin
          if (tx_bit_end) begin
            tx_clk_cnt <= '0;
            if (tx_bit_idx == HI_LAST) begin
              state  <= WAIT_LO;
              tx_out <= 1'b1;
`ifdef PUF_HOST_TIMEOUT_EN
              wd_cnt <= '0;
`endif
            end else begin
              tx_shift   <= {1'b1, tx_shift[UART_FRAME_BITS:1]};
              tx_out     <= tx_shift[1];
              tx_bit_idx <= tx_bit_idx + 1'b1;
            end
          end else begin
            tx_clk_cnt <= tx_clk_cnt + 1'b1;
          end
        end

        WAIT_LO: begin
          if (byte_valid) begin
            resp_lo <= byte_data;
            state   <= WAIT_HI;
`ifdef PUF_HOST_TIMEOUT_EN
            wd_cnt  <= '0;
          end else if (wd_expired) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end

        WAIT_HI: begin
          if (byte_valid) begin
            crp_response  <= {byte_data, resp_lo};
            crp_challenge <= cur_chal;
            crp_valid     <= 1'b1;
            state         <= EMIT;
`ifdef PUF_HOST_TIMEOUT_EN
          end else if (wd_expired) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end

        EMIT: begin
          if (crp_ready) begin
            crp_valid <= 1'b0;
            remaining <= remaining - 1'b1;
            cur_chal  <= cur_chal + 1'b1;  // natural 16-bit wrap
            state     <= NEXT;
          end
        end

        NEXT: begin
          if (remaining != 16'h0000) begin
            state      <= SEND_LO;
            tx_shift   <= uart_frame(cur_chal[7:0]);
            tx_out     <= 1'b0;
            tx_bit_idx <= '0;
            tx_clk_cnt <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_host_16.sv
// Bench for puf_host_16: table of single exchanges plus hand-written sweeps
// (zero count, wrap-around, back-pressure, framing error, watchdog, reset mid-byte).
// Runs with a short bit time so every sequence stays small.
module tb_puf_host_16;
  import puf_host_pkg::*;

  localparam int CPB = 8;
  localparam int TMO = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] chal_first = '0;
  logic [15:0] chal_count = '0;
  logic        tx_out;
  logic        rx_in = 1'b1;
  logic        crp_valid;
  logic        crp_ready = 1'b0;
  logic [15:0] crp_challenge;
  logic [15:0] crp_response;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  puf_host_16 #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .chal_first    (chal_first),
    .chal_count    (chal_count),
    .tx_out        (tx_out),
    .rx_in         (rx_in),
    .crp_valid     (crp_valid),
    .crp_ready     (crp_ready),
    .crp_challenge (crp_challenge),
    .crp_response  (crp_response),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic [15:0] chal;
    logic [15:0] resp;
    logic [7:0]  tx_lo;
    logic [7:0]  tx_hi;
  } vec_t;

  vec_t vecs [4];
  vec_t wrap [3];

  logic [7:0] b;
  bit         ok;
  int         n;
  int         bad_a;
  int         bad_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after start was sampled.
  task automatic pulse_start(input logic [15:0] f, input logic [15:0] c);
    chal_first = f;
    chal_count = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Device-side receive of one byte from tx_out, sampled mid-bit.
  task automatic uart_get(output logic [7:0] data, output bit good);
    int w;
    good = 1'b0;
    data = '0;
    w = 0;
    while (tx_out !== 1'b0 && w < 40 * CPB) begin
      @(negedge clk);
      w++;
    end
    if (tx_out !== 1'b0) return;
    repeat (CPB / 2) @(negedge clk);
    if (tx_out !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      data[i] = tx_out;
    end
    repeat (CPB) @(negedge clk);
    good = (tx_out === 1'b1);
  endtask

  // Device-side transmit of one byte; stop selects a good or broken stop bit.
  task automatic uart_put(input logic [7:0] data, input logic stop);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop;
    repeat (CPB) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic wait_valid(output bit good);
    int w;
    w = 0;
    while (crp_valid !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    good = (crp_valid === 1'b1);
  endtask

  task automatic accept();
    crp_ready = 1'b1;
    @(negedge clk);
    crp_ready = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
  endtask

  // One challenge on the wire, one response back, one record out.
  task automatic exchange(input string tag, input vec_t v);
    bit         g;
    logic [7:0] d;
    uart_get(d, g);
    check({tag, "_tx_lo_frame"}, g, 1'b1);
    check({tag, "_tx_lo"}, d, v.tx_lo);
    uart_get(d, g);
    check({tag, "_tx_hi_frame"}, g, 1'b1);
    check({tag, "_tx_hi"}, d, v.tx_hi);
    tick(CPB);
    uart_put(v.resp[7:0], 1'b1);
    uart_put(v.resp[15:8], 1'b1);
    wait_valid(g);
    check({tag, "_valid"}, g, 1'b1);
    check({tag, "_challenge"}, crp_challenge, v.chal);
    check({tag, "_response"}, crp_response, v.resp);
    accept();
    check({tag, "_valid_drop"}, crp_valid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{chal: 16'h1234, resp: PUF_CHECK_WORD, tx_lo: 8'h34, tx_hi: 8'h12};
    vecs[1] = '{chal: 16'h0000, resp: 16'hFFFF,       tx_lo: 8'h00, tx_hi: 8'h00};
    vecs[2] = '{chal: 16'hFFFF, resp: 16'h0001,       tx_lo: 8'hFF, tx_hi: 8'hFF};
    vecs[3] = '{chal: 16'h80A5, resp: 16'h5AC3,       tx_lo: 8'hA5, tx_hi: 8'h80};
    wrap[0] = '{chal: 16'hFFFE, resp: 16'h1111,       tx_lo: 8'hFE, tx_hi: 8'hFF};
    wrap[1] = '{chal: 16'hFFFF, resp: 16'h2222,       tx_lo: 8'hFF, tx_hi: 8'hFF};
    wrap[2] = '{chal: 16'h0000, resp: 16'h3333,       tx_lo: 8'h00, tx_hi: 8'h00};

    // Reset state
    tick(3);
    check("rst_tx_out", tx_out, 1'b1);
    check("rst_crp_valid", crp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_crp_challenge", crp_challenge, 16'h0000);
    check("rst_crp_response", crp_response, 16'h0000);
    rst_n = 1'b1;
    tick(4);

    // Single-challenge sweeps from the table
    for (int v = 0; v < 4; v++) begin
      pulse_start(vecs[v].chal, 16'd1);
      check("vec_busy_rise", busy, 1'b1);
      check("vec_start_bit", tx_out, 1'b0);
      exchange("vec", vecs[v]);
      count_done(10, n);
      check("vec_done_pulses", n, 1);
      check("vec_busy_fall", busy, 1'b0);
      tick(5);
    end

    // Zero-length sweep: done next cycle, no traffic, busy stays low
    pulse_start(16'h5A5A, 16'd0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    bad_a = 0;
    repeat (4 * CPB) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad_a++;
    end
    check("zero_quiet", bad_a, 0);

    // Wrap-around across 16'hFFFF
    pulse_start(16'hFFFE, 16'd3);
    for (int i = 0; i < 3; i++) exchange("wrap", wrap[i]);
    count_done(10, n);
    check("wrap_done_pulses", n, 1);

    // Back-pressure: record held, line idle, no second challenge, start ignored
    pulse_start(16'h0100, 16'd2);
    exchange_hold: begin
      uart_get(b, ok);
      check("bp_tx_lo", b, 8'h00);
      uart_get(b, ok);
      check("bp_tx_hi", b, 8'h01);
      tick(CPB);
      uart_put(8'h22, 1'b1);
      uart_put(8'h22, 1'b1);
      wait_valid(ok);
      check("bp_valid", ok, 1'b1);
      bad_a = 0;
      bad_b = 0;
      chal_first = 16'h9999;
      chal_count = 16'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5000) begin
        @(negedge clk);
        if (crp_valid !== 1'b1 || crp_challenge !== 16'h0100 || crp_response !== 16'h2222) bad_a++;
        if (tx_out !== 1'b1) bad_b++;
      end
      check("bp_record_stable", bad_a, 0);
      check("bp_tx_idle", bad_b, 0);
      accept();
    end
    exchange("bp_second", '{chal: 16'h0101, resp: 16'h3C3C, tx_lo: 8'h01, tx_hi: 8'h01});
    count_done(10, n);
    check("bp_done_pulses", n, 1);

    // Framing error: broken byte dropped, next two bytes form the response
    pulse_start(16'h4321, 16'd1);
    uart_get(b, ok);
    check("fe_tx_lo", b, 8'h21);
    uart_get(b, ok);
    check("fe_tx_hi", b, 8'h43);
    tick(CPB);
    uart_put(8'h77, 1'b0);
    uart_put(8'hEF, 1'b1);
    check("fe_no_early_valid", crp_valid, 1'b0);
    uart_put(8'hBE, 1'b1);
    wait_valid(ok);
    check("fe_valid", ok, 1'b1);
    check("fe_challenge", crp_challenge, 16'h4321);
    check("fe_response", crp_response, 16'hBEEF);
    accept();
    count_done(10, n);
    check("fe_done_pulses", n, 1);

`ifdef PUF_HOST_TIMEOUT_EN
    // Silent device: watchdog aborts, no record, flag sticky until next start
    pulse_start(16'h5555, 16'd2);
    uart_get(b, ok);
    uart_get(b, ok);
    check("to_tx_hi", b, 8'h55);
    bad_a = 0;
    n = 0;
    for (int w = 0; w < TMO + 40 * CPB && n == 0; w++) begin
      @(negedge clk);
      if (crp_valid === 1'b1) bad_a++;
      if (done === 1'b1) n++;
    end
    check("to_done_seen", n, 1);
    check("to_no_record", bad_a, 0);
    check("to_err_set", timeout_err, 1'b1);
    check("to_busy_fall", busy, 1'b0);
    tick(3);
    check("to_err_sticky", timeout_err, 1'b1);
    pulse_start(16'h0000, 16'd0);
    check("to_err_cleared", timeout_err, 1'b0);
    tick(3);
`endif

    // Reset mid-byte: line returns high before the next clock edge
    pulse_start(16'h0000, 16'd1);
    tick(CPB + 2);
    check("mid_tx_low", tx_out, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_high", tx_out, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_a = 0;
    repeat (20 * CPB) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad_a++;
    end
    check("mid_rst_abandoned", bad_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
